// File: rtl/x1_mem_pkg.sv
// Shared types for the X1 IPL RAM loader/arbiter: sequencer states, download index and
// the layout of a buffered download byte.
package x1_mem_pkg;

    localparam int unsigned IplAw    = 12;
    localparam logic [7:0]  IplIndex = 8'h00;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StHold,
        StRun
    } ld_state_e;

    // Packed as {addr, data}; the loader FIFO uses the same bit order.
    typedef struct packed {
        logic [IplAw-1:0] addr;
        logic [7:0]       data;
    } fifo_entry_t;

endpackage

// File: rtl/x1_wr_fifo.sv
// Two-entry synchronous FIFO. A push on a full FIFO is dropped unless a pop happens
// in the same cycle.
module x1_wr_fifo #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_q] = din;
        end
        wr_d  = wr_q ^ do_push;
        rd_d  = rd_q ^ do_pop;
        cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/x1_ipl_loader_arb.sv
// Shares port A of the X1 IPL RAM between the HPS ioctl download stream and the Z80,
// holding the CPU in reset while a load is streamed in.
module x1_ipl_loader_arb
    import x1_mem_pkg::*;
#(
    parameter int unsigned AW         = 12,
    parameter logic [7:0]  LOAD_INDEX = IplIndex,
    parameter int unsigned RST_HOLD   = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_q,
    output logic          cpu_reset,
    output logic          load_done,
    output logic          load_overflow,
    output logic [AW:0]   load_count
);

    localparam int unsigned FW       = AW + 8;
    localparam logic [AW:0] CountMax = {1'b1, {AW{1'b0}}};

    ld_state_e   state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [AW:0] count_q, count_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        busy_we_q, busy_we_d;
    logic [7:0]  dout_q, dout_d;

    logic          dl_active, addr_oob, wr_ok, push, pop, accept;
    logic          full, empty;
    logic [FW-1:0] fifo_din, fifo_dout;

    assign dl_active = ioctl_download && (ioctl_index == LOAD_INDEX);
    assign addr_oob  = |ioctl_addr[24:AW];
    assign wr_ok     = dl_active && ioctl_wr && !reset;
    assign push      = wr_ok && !addr_oob;
    assign fifo_din  = {ioctl_addr[AW-1:0], ioctl_dout};
    assign pop       = ((state_q == StLoad) || (state_q == StFlush)) && !empty && !reset;
    // A rising download blocks new CPU accesses so the one in flight finishes first.
    assign accept    = (state_q == StRun) && cpu_req && !busy_q && !dl_active && !reset;

    x1_wr_fifo #(
        .WIDTH(FW)
    ) u_fifo (
        .clk  (clk_sys),
        .reset(reset),
        .push (push),
        .din  (fifo_din),
        .pop  (pop),
        .full (full),
        .empty(empty),
        .dout (fifo_dout)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        count_d   = count_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        busy_d    = accept;
        busy_we_d = accept ? cpu_we : busy_we_q;
        dout_d    = dout_q;
        ram_addr  = '0;
        ram_din   = '0;
        ram_we    = 1'b0;

        if (wr_ok && (addr_oob || (full && !pop))) begin
            ovf_d = 1'b1;
        end

        if (pop) begin
            ram_we   = 1'b1;
            ram_addr = fifo_dout[FW-1:8];
            ram_din  = fifo_dout[7:0];
            if (count_q != CountMax) begin
                count_d = count_q + (AW+1)'(1);
            end
        end else if (accept) begin
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_din  = cpu_din;
        end

        if (busy_q && !busy_we_q) begin
            dout_d = ram_q;
        end

        unique case (state_q)
            StIdle: begin
                if (dl_active) state_d = StLoad;
            end
            StLoad: begin
                if (!dl_active) state_d = StFlush;
            end
            StFlush: begin
                if (empty) begin
                    done_d = 1'b1;
                    if (RST_HOLD == 0) begin
                        state_d = StRun;
                    end else begin
                        state_d = StHold;
                        hold_d  = 16'(RST_HOLD);
                    end
                end
            end
            StHold: begin
                hold_d = hold_q - 16'd1;
                if (hold_q <= 16'd1) state_d = StRun;
            end
            StRun: begin
                if (dl_active) begin
                    state_d = StLoad;
                    count_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            busy_we_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            busy_we_q <= busy_we_d;
            dout_q    <= dout_d;
        end
    end

    // Reset is released during the last hold cycle so it falls RST_HOLD+1 cycles after
    // the final byte is written.
    assign cpu_reset     = !((state_q == StRun) || ((state_q == StHold) && (hold_q == 16'd1)));
    assign cpu_ack       = busy_q;
    assign cpu_dout      = (busy_q && !busy_we_q) ? ram_q : dout_q;
    assign load_done     = done_q;
    assign load_overflow = ovf_q;
    assign load_count    = count_q;

endmodule

// File: tb/tb_x1_ipl_loader_arb.sv
// Scoreboard bench for x1_ipl_loader_arb: directed loads and CPU accesses push expected
// RAM writes and ack data into queues that a negedge monitor drains.
module tb_x1_ipl_loader_arb;

    localparam int unsigned AW       = 12;
    localparam int unsigned RST_HOLD = 16;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_q;
    logic          cpu_reset;
    logic          load_done;
    logic          load_overflow;
    logic [AW:0]   load_count;

    x1_ipl_loader_arb #(
        .AW        (AW),
        .LOAD_INDEX(8'h00),
        .RST_HOLD  (RST_HOLD)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_din       (cpu_din),
        .cpu_dout      (cpu_dout),
        .cpu_ack       (cpu_ack),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_we        (ram_we),
        .ram_q         (ram_q),
        .cpu_reset     (cpu_reset),
        .load_done     (load_done),
        .load_overflow (load_overflow),
        .load_count    (load_count)
    );

    always #5 clk_sys = ~clk_sys;

    // Behavioural IPL RAM with one-cycle registered read.
    logic [7:0] mem [4096];
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_seen = 0;
    int first_we_cyc = -1;
    int last_we_cyc = -1;
    int first_wr_cyc = 0;
    int fall = -1;
    int t0 = 0;

    logic [19:0] exp_wr_q [$];
    logic [7:0]  exp_ack_q [$];
    logic [19:0] ew;
    logic [7:0]  ea;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (reset === 1'b0) begin
            if (ram_we === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ram_we: got addr=%0h data=%0h expected no write",
                             ram_addr, ram_din);
                end else begin
                    ew = exp_wr_q.pop_front();
                    check("ram_write", {12'd0, ram_addr, ram_din}, {12'd0, ew});
                end
                if (first_we_cyc < 0) first_we_cyc = cyc;
                last_we_cyc = cyc;
            end
            if (cpu_ack === 1'b1) begin
                ack_seen++;
                if (exp_ack_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack dout=%0h expected no ack", cpu_dout);
                end else begin
                    ea = exp_ack_q.pop_front();
                    check("ack_dout", {24'd0, cpu_dout}, {24'd0, ea});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_run(output int f);
        f = -1;
        for (int i = 0; i < 200 && f < 0; i++) begin
            @(negedge clk_sys);
            if (cpu_reset === 1'b0) f = cyc;
        end
    endtask

    // Issues one CPU access and checks the ack arrives the cycle after acceptance.
    task automatic cpu_access(input logic we, input logic [11:0] a, input logic [7:0] d,
                              input logic [7:0] exp_dout, input string nm);
        int  ts;
        bit  got;
        exp_ack_q.push_back(exp_dout);
        if (we) exp_wr_q.push_back({a, d});
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_addr = a;
        cpu_din  = d;
        ts       = cyc;
        got      = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_sys);
            if (cpu_ack === 1'b1) got = 1'b1;
        end
        check(nm, got ? 32'(cyc - ts) : 32'd99, 32'd1);
        tick();
        cpu_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        cpu_req        = 1'b0;
        cpu_we         = 1'b0;
        cpu_addr       = '0;
        cpu_din        = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_overflow", 32'(load_overflow), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);

        // Power-on: a held request must not be served before any load.
        tick();
        cpu_req = 1'b1;
        repeat (20) tick();
        cpu_req = 1'b0;
        check("poweron_no_ack", 32'(ack_seen), 32'd0);
        check("poweron_cpu_reset", 32'(cpu_reset), 32'd1);

        // Download for another index is ignored entirely.
        ioctl_download = 1'b1;
        ioctl_index    = 8'h01;
        for (int i = 0; i < 64; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'(i + 8'h80);
            tick();
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        repeat (40) tick();
        check("wrongidx_cpu_reset", 32'(cpu_reset), 32'd1);
        check("wrongidx_load_done", 32'(load_done), 32'd0);
        check("wrongidx_load_count", 32'(load_count), 32'd0);

        // Full 4 KiB load, one strobe per cycle, data = addr[7:0].
        ioctl_index    = 8'h00;
        ioctl_download = 1'b1;
        first_we_cyc   = -1;
        first_wr_cyc   = cyc;
        for (int i = 0; i < 4096; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'(i);
            exp_wr_q.push_back({12'(i), 8'(i)});
            tick();
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        wait_run(fall);
        check("ioctl_to_ram_latency", 32'(first_we_cyc - first_wr_cyc), 32'd1);
        check("hold_release", 32'(fall - last_we_cyc), 32'(RST_HOLD + 1));
        check("full_load_count", 32'(load_count), 32'd4096);
        check("full_load_done", 32'(load_done), 32'd1);
        check("full_load_overflow", 32'(load_overflow), 32'd0);
        check("full_load_drained", 32'(exp_wr_q.size()), 32'd0);
        tick();

        // CPU accesses in RUN; cpu_dout holds the last read value across write acks.
        cpu_access(1'b1, 12'h123, 8'h5A, 8'h00, "cpu_wr_123_latency");
        cpu_access(1'b0, 12'h123, 8'h00, 8'h5A, "cpu_rd_123_latency");
        cpu_access(1'b0, 12'h042, 8'h00, 8'h42, "cpu_rd_042_latency");
        cpu_access(1'b1, 12'h124, 8'h77, 8'h42, "cpu_wr_124_latency");
        cpu_access(1'b0, 12'hFFF, 8'h00, 8'hFF, "cpu_rd_fff_latency");
        repeat (3) tick();
        check("cpu_dout_hold", 32'(cpu_dout), 32'hFF);

        // Reload starting while a read is in its ack cycle; includes an out-of-range byte.
        exp_ack_q.push_back(8'h5A);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 12'h123;
        t0       = cyc;
        tick();
        ioctl_download = 1'b1;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'h0010;
        ioctl_dout     = 8'hA5;
        exp_wr_q.push_back({12'h010, 8'hA5});
        @(negedge clk_sys);
        check("reload_ack", 32'(cpu_ack), 32'd1);
        check("reload_reset_low_during_ack", 32'(cpu_reset), 32'd0);
        tick();
        cpu_req    = 1'b0;
        ioctl_addr = 25'h1000;
        ioctl_dout = 8'hEE;
        @(negedge clk_sys);
        check("reload_reset_high", 32'(cpu_reset), 32'd1);
        check("reload_first_pop", 32'(ram_we), 32'd1);
        tick();
        ioctl_addr = 25'h0011;
        ioctl_dout = 8'h5B;
        exp_wr_q.push_back({12'h011, 8'h5B});
        tick();
        ioctl_addr = 25'h0012;
        ioctl_dout = 8'hC3;
        exp_wr_q.push_back({12'h012, 8'hC3});
        tick();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check("oob_overflow", 32'(load_overflow), 32'd1);
        repeat (2) tick();
        ioctl_download = 1'b0;
        wait_run(fall);
        check("reload_reaches_run", 32'(fall >= 0), 32'd1);
        check("reload_count", 32'(load_count), 32'd3);
        check("reload_done", 32'(load_done), 32'd1);
        tick();
        cpu_access(1'b0, 12'h011, 8'h00, 8'h5B, "cpu_rd_011_latency");
        cpu_access(1'b0, 12'h000, 8'h00, 8'h00, "cpu_rd_000_latency");
        cpu_access(1'b0, 12'h010, 8'h00, 8'hA5, "cpu_rd_010_latency");

        // Reset in the middle of a load.
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'h0200;
        ioctl_dout     = 8'h30;
        exp_wr_q.push_back({12'h200, 8'h30});
        tick();
        ioctl_addr = 25'h0201;
        ioctl_dout = 8'h31;
        exp_wr_q.push_back({12'h201, 8'h31});
        tick();
        ioctl_addr = 25'h0202;
        ioctl_dout = 8'h32;
        tick();
        reset          = 1'b1;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk_sys);
        check("midload_ram_we", 32'(ram_we), 32'd0);
        check("midload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midload_load_done", 32'(load_done), 32'd0);
        check("midload_load_overflow", 32'(load_overflow), 32'd0);
        check("midload_load_count", 32'(load_count), 32'd0);
        check("midload_writes_before_reset", 32'(exp_wr_q.size()), 32'd0);
        repeat (30) tick();
        check("midload_stays_idle", 32'(cpu_reset), 32'd1);
        check("acks_drained", 32'(exp_ack_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
